// File: rtl/adder_ncnet_pipe.sv
// Two-stage signed three-operand adder (add1 + add2 - miuns) with per-beat
// wrap/saturate mode, per-beat overflow flag and a sticky overflow latch.
module adder_ncnet_pipe #(
  parameter int P_DATA_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ce,
  input  logic                    i_valid,
  input  logic                    i_mode,
  input  logic [P_DATA_WIDTH-1:0] i_add1,
  input  logic [P_DATA_WIDTH-1:0] i_add2,
  input  logic [P_DATA_WIDTH-1:0] i_miuns,
  input  logic                    i_ovf_clr,
  output logic [P_DATA_WIDTH-1:0] o_sum,
  output logic                    o_valid,
  output logic                    o_ovf,
  output logic                    o_ovf_sticky
);

  localparam int W  = P_DATA_WIDTH;
  localparam int WX = P_DATA_WIDTH + 2;

  // Signed range limits, both in the widened domain and at output width.
  localparam logic signed [WX-1:0] MAX_X = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [WX-1:0] MIN_X = {3'b111, {(W-1){1'b0}}};
  localparam logic [W-1:0]         MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         MIN_W = {1'b1, {(W-1){1'b0}}};

  logic signed [WX-1:0] add1_x, add2_x, miuns_x;

  logic signed [WX-1:0] s1_sum_d, s1_sum_q;
  logic signed [WX-1:0] s1_miuns_d, s1_miuns_q;
  logic                 s1_mode_d, s1_mode_q;
  logic                 s1_valid_d, s1_valid_q;

  logic signed [WX-1:0] res_x;
  logic                 pos_ovf, neg_ovf;
  logic                 res_ovf;
  logic [W-1:0]         res_sum;

  logic [W-1:0]         sum_d, sum_q;
  logic                 valid_d, valid_q;
  logic                 ovf_d, ovf_q;
  logic                 sticky_d, sticky_q;

  assign add1_x  = {{2{i_add1[W-1]}}, i_add1};
  assign add2_x  = {{2{i_add2[W-1]}}, i_add2};
  assign miuns_x = {{2{i_miuns[W-1]}}, i_miuns};

  always_comb begin
    s1_sum_d   = s1_sum_q;
    s1_miuns_d = s1_miuns_q;
    s1_mode_d  = s1_mode_q;
    s1_valid_d = s1_valid_q;
    if (i_ce) begin
      s1_sum_d   = add1_x + add2_x;
      s1_miuns_d = miuns_x;
      s1_mode_d  = i_mode;
      s1_valid_d = i_valid;
    end
  end

  // Subtraction happens two bits wide of the operands, so -2^(W-1) negates exactly.
  always_comb begin
    res_x   = s1_sum_q - s1_miuns_q;
    pos_ovf = (res_x > MAX_X);
    neg_ovf = (res_x < MIN_X);
    res_ovf = s1_valid_q & (pos_ovf | neg_ovf);
    res_sum = '0;
    if (s1_valid_q) begin
      if (s1_mode_q && pos_ovf)      res_sum = MAX_W;
      else if (s1_mode_q && neg_ovf) res_sum = MIN_W;
      else                           res_sum = res_x[W-1:0];
    end
  end

  always_comb begin
    sum_d   = sum_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (i_ce) begin
      sum_d   = res_sum;
      valid_d = s1_valid_q;
      ovf_d   = res_ovf;
    end
  end

  // Set only on an enabled capture of an overflowing beat; clear ignores i_ce; set wins.
  always_comb begin
    sticky_d = sticky_q;
    if (i_ce && res_ovf) sticky_d = 1'b1;
    else if (i_ovf_clr)  sticky_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_sum_q   <= '0;
      s1_miuns_q <= '0;
      s1_mode_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_sum_q   <= s1_sum_d;
      s1_miuns_q <= s1_miuns_d;
      s1_mode_q  <= s1_mode_d;
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign o_sum        = sum_q;
  assign o_valid      = valid_q;
  assign o_ovf        = ovf_q;
  assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_adder_ncnet_pipe.sv
// Directed-vector bench for adder_ncnet_pipe at the default 4-bit width.
module tb_adder_ncnet_pipe;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic         valid;
  logic         mode;
  logic [W-1:0] add1, add2, miuns;
  logic         ovf_clr;
  logic [W-1:0] sum;
  logic         o_valid;
  logic         ovf;
  logic         sticky;

  int n_vec;
  int n_err;
  int n_seen;
  int run_len;
  int max_run;

  // Expected beats as {ovf, sum}, popped whenever o_valid is seen.
  logic [W:0] exp_q[$];

  adder_ncnet_pipe #(.P_DATA_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ce         (ce),
    .i_valid      (valid),
    .i_mode       (mode),
    .i_add1       (add1),
    .i_add2       (add2),
    .i_miuns      (miuns),
    .i_ovf_clr    (ovf_clr),
    .o_sum        (sum),
    .o_valid      (o_valid),
    .o_ovf        (ovf),
    .o_ovf_sticky (sticky)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
    valid = v;
    mode  = m;
    add1  = a;
    add2  = b;
    miuns = c;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Advance one cycle and score any beat that emerges.
  task automatic tick();
    logic [W:0] e;
    step();
    if (o_valid) begin
      n_seen++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
        chk("sb_ovf", 32'(ovf), 32'(e[W]));
      end
    end else begin
      run_len = 0;
    end
  endtask

  task automatic drain(input string tag);
    bubble();
    repeat (3) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_seen = 0; run_len = 0; max_run = 0;
    rst_n = 1'b0; ce = 1'b1; ovf_clr = 1'b0;
    bubble();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    #3 rst_n = 1'b1;
    step();

    // Wrap overflow: 7 + 7 - (-8) = 22 -> 0110
    drive(1'b1, 1'b0, 4'd7, 4'd7, 4'b1000);
    step();
    bubble();
    step();
    chk("wrap_valid", 32'(o_valid), 32'd1);
    chk("wrap_sum", 32'(sum), 32'b0110);
    chk("wrap_ovf", 32'(ovf), 32'd1);
    step();
    chk("wrap_sticky", 32'(sticky), 32'd1);
    chk("bubble_valid", 32'(o_valid), 32'd0);
    chk("bubble_sum", 32'(sum), 32'd0);
    chk("bubble_ovf", 32'(ovf), 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_sticky", 32'(sticky), 32'd0);

    // Saturate vectors, back to back
    drive(1'b1, 1'b1, 4'd7, 4'd7, 4'b1000); exp_q.push_back({1'b1, 4'b0111}); tick();
    drive(1'b1, 1'b1, 4'b1000, 4'b1000, 4'd7); exp_q.push_back({1'b1, 4'b1000}); tick();
    drive(1'b1, 1'b1, 4'd3, 4'b1110, 4'd1); exp_q.push_back({1'b0, 4'b0000}); tick();
    drive(1'b1, 1'b0, 4'd2, 4'd3, 4'b1000); exp_q.push_back({1'b1, 4'b1101}); tick();
    drive(1'b1, 1'b1, 4'b1001, 4'd1, 4'd2); exp_q.push_back({1'b0, 4'b1000}); tick();
    drain("sat_drain");
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Throughput with alternating mode: 7 + 1 - 0 = 8
    n_seen = 0; max_run = 0; run_len = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[0], 4'd7, 4'd1, 4'd0);
      exp_q.push_back(i[0] ? {1'b1, 4'b0111} : {1'b1, 4'b1000});
      tick();
    end
    drain("tput_drain");
    chk("tput_count", 32'(n_seen), 32'd8);
    chk("tput_run", 32'(max_run), 32'd8);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Stall: beat A out, beat B held in stage 1 for 3 disabled edges
    drive(1'b1, 1'b0, 4'd3, 4'd2, 4'd1);
    step();
    drive(1'b1, 1'b0, 4'b1000, 4'b1000, 4'd7);
    step();
    chk("stall_a_valid", 32'(o_valid), 32'd1);
    chk("stall_a_sum", 32'(sum), 32'd4);
    bubble();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_valid", 32'(o_valid), 32'd1);
      chk("stall_hold_sum", 32'(sum), 32'd4);
      chk("stall_hold_ovf", 32'(ovf), 32'd0);
    end
    ce = 1'b1;
    step();
    chk("stall_b_valid", 32'(o_valid), 32'd1);
    chk("stall_b_sum", 32'(sum), 32'b1001);
    chk("stall_b_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("stall_clr", 32'(sticky), 32'd0);

    // Sticky: set and clear coincide, then clear alone
    drive(1'b1, 1'b0, 4'd7, 4'd7, 4'b1000);
    step();
    bubble();
    ovf_clr = 1'b1;
    step();
    chk("sticky_set_wins", 32'(sticky), 32'd1);
    chk("sticky_beat_ovf", 32'(ovf), 32'd1);
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr", 32'(sticky), 32'd0);

    // Reset mid-flight
    drive(1'b1, 1'b0, 4'd7, 4'd7, 4'b1000);
    step();
    drive(1'b1, 1'b0, 4'd1, 4'd2, 4'd0);
    step();
    bubble();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_sticky", 32'(sticky), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_valid", 32'(o_valid), 32'd0);
    end
    drive(1'b1, 1'b0, 4'd1, 4'd1, 4'd1);
    step();
    bubble();
    chk("post_rst_lat1", 32'(o_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'd1);
    chk("post_rst_ovf", 32'(ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_ncnet_pipe.md
ADDER_NCNET_PIPE -- requirements
Module: ADDER_NCNET_PIPE

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 4: operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_ce, input, 1: pipeline enable; when low, every register holds.
REQ-005 SHALL have port i_valid, input, 1: operand set valid this cycle.
REQ-006 SHALL have port i_mode, input, 1: 0 = wrap (modulo 2^P_DATA_WIDTH), 1 = signed saturate.
REQ-007 SHALL have ports i_add1, i_add2, i_miuns, input, P_DATA_WIDTH each: two's-complement signed operands.
REQ-008 SHALL have port i_ovf_clr, input, 1: clears the sticky overflow flag.
REQ-009 SHALL have port o_sum, output, P_DATA_WIDTH: registered result.
REQ-010 SHALL have port o_valid, output, 1: o_sum/o_ovf qualify this cycle.
REQ-011 SHALL have port o_ovf, output, 1: result of the current o_valid beat was out of signed range.
REQ-012 SHALL have port o_ovf_sticky, output, 1: latched overflow since last clear.

Function
REQ-013 SHALL compute exact r = i_add1 + i_add2 - i_miuns in P_DATA_WIDTH+2 bits, sign-extended; no intermediate truncation.
REQ-014 SHALL negate i_miuns in widened arithmetic, so i_miuns = -2^(P_DATA_WIDTH-1) yields +2^(P_DATA_WIDTH-1) exactly.
REQ-015 SHALL be a two-stage pipeline: stage 1 registers s1 = i_add1 + i_add2, the widened i_miuns, i_mode and i_valid; stage 2 registers the final result, o_ovf and o_valid.
REQ-016 SHALL give latency exactly 2 enabled cycles (i_ce=1) from the i_valid sample to o_valid.
REQ-017 SHALL accept one operand set per enabled cycle (throughput 1) with no backpressure.
REQ-018 SHALL, when i_ce=0, hold all stage-1 and stage-2 registers, including o_valid, o_sum and o_ovf.
REQ-019 SHALL set o_ovf=1 when r < -2^(P_DATA_WIDTH-1) or r > 2^(P_DATA_WIDTH-1)-1, in both modes.
REQ-020 SHALL, in wrap mode, output o_sum = r[P_DATA_WIDTH-1:0], bit-identical to the legacy 4-bit adder at P_DATA_WIDTH=4.
REQ-021 SHALL, in saturate mode, clamp o_sum to 2^(P_DATA_WIDTH-1)-1 on positive overflow and to -2^(P_DATA_WIDTH-1) on negative overflow, and otherwise output r.
REQ-022 SHALL apply i_mode per beat, carried through the pipeline with its data; a mode change takes effect for the next accepted beat only.
REQ-023 SHALL, when i_valid=0 on an enabled cycle, propagate a bubble: o_valid=0 and o_ovf=0 two enabled cycles later; o_sum is don't-care but SHALL be 0.
REQ-024 SHALL set o_ovf_sticky on any enabled cycle where the stage-2 next state has valid=1 and ovf=1, independent of i_ce for clearing.
REQ-025 SHALL clear o_ovf_sticky on a cycle with i_ovf_clr=1; if set and clear coincide, set wins.

Reset
REQ-026 SHALL, while i_rst_n=0, asynchronously force o_sum=0, o_valid=0, o_ovf=0, o_ovf_sticky=0 and all stage-1 registers to 0.
REQ-027 SHALL discard in-flight beats on reset; the first o_valid after release comes 2 enabled cycles after the first post-reset i_valid.
REQ-028 SHALL ignore i_ce and i_ovf_clr during reset.

Verification (P_DATA_WIDTH=4)
REQ-029 Wrap: add1=7, add2=7, miuns=-8, mode=0, i_valid=1 -> 2 cycles later o_valid=1, o_sum=4'b0110, o_ovf=1, o_ovf_sticky=1 on the following cycle.
REQ-030 Saturate: (7,7,-8) -> o_sum=4'b0111, o_ovf=1; (-8,-8,7) -> o_sum=4'b1000, o_ovf=1; (3,-2,1) -> o_sum=0, o_ovf=0.
REQ-031 Stall: issue a beat, drop i_ce for 3 cycles after cycle 1 -> o_valid appears 5 cycles after issue; outputs stay constant during the stall.
REQ-032 Throughput and mode switch: 8 back-to-back beats alternating mode, operands (7,1,0) -> o_valid high 8 consecutive cycles; o_sum alternates 4'b1000 (wrap) and 4'b0111 (sat).
REQ-033 Sticky: overflow beat reaches stage 2 in the same cycle as i_ovf_clr=1 -> o_ovf_sticky remains 1; i_ovf_clr alone next cycle -> 0.
REQ-034 Reset mid-flight: two beats in pipeline, pulse i_rst_n low asynchronously between edges -> all outputs 0 immediately; no stale o_valid after release.
